// File: rtl/tetris_timing_pkg.sv
// Shared timing definitions for the Tetris gravity/lock scheduler.
//   sched_state_t     : scheduler FSM states
//   gravity_frames()  : frames per gravity drop for levels 0..15
//   *_DEFAULT         : default lock delay, soft-drop period and lock-reset budget
package tetris_timing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_LOCK,
    ST_PAUSE,
    ST_OVER
  } sched_state_t;

  localparam int unsigned LOCK_FRAMES_DEFAULT      = 30;
  localparam int unsigned SOFT_DROP_FRAMES_DEFAULT = 2;
  localparam int unsigned MAX_LOCK_RESETS_DEFAULT  = 15;

  function automatic logic [5:0] gravity_frames(input logic [3:0] lvl);
    logic [5:0] f;
    case (lvl)
      4'd0:    f = 6'd48;
      4'd1:    f = 6'd43;
      4'd2:    f = 6'd38;
      4'd3:    f = 6'd33;
      4'd4:    f = 6'd28;
      4'd5:    f = 6'd23;
      4'd6:    f = 6'd18;
      4'd7:    f = 6'd13;
      4'd8:    f = 6'd8;
      4'd9:    f = 6'd6;
      4'd10,
      4'd11,
      4'd12:   f = 6'd5;
      default: f = 6'd4;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/frame_prescaler.sv
// Divides the system clock down to the frame rate.
//   clock  : system clock
//   reset  : synchronous active-low reset
//   enable : count only while high; the count holds otherwise
//   clear  : return the count to zero and cancel a pending tick
//   tick   : registered one-cycle pulse in the cycle after the count wraps
module frame_prescaler #(
  parameter int unsigned DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (enable) begin
        if (cnt == W'(DIV - 1)) begin
          cnt  <= '0;
          tick <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/drop_scheduler.sv
// Gravity and lock-delay scheduler: turns the frame tick into drop and lock pulses.
//   clock, reset                : system clock, synchronous active-low reset
//   start, pause_toggle,
//   game_over                   : game control pulses from the top-level FSM
//   level, soft_drop            : select the gravity period
//   grounded, lock_reset        : piece contact state and move/rotate-while-grounded pulse
//   frame_tick, drop_tick,
//   lock_tick                   : registered one-cycle pulses
//   running, paused             : state flags, one cycle behind the FSM
//   frames_per_drop             : registered effective gravity period
module drop_scheduler
  import tetris_timing_pkg::*;
#(
  parameter int unsigned CLK_HZ           = 100_000_000,
  parameter int unsigned FRAME_HZ         = 60,
  parameter int unsigned LOCK_FRAMES      = LOCK_FRAMES_DEFAULT,
  parameter int unsigned SOFT_DROP_FRAMES = SOFT_DROP_FRAMES_DEFAULT,
  parameter int unsigned MAX_LOCK_RESETS  = MAX_LOCK_RESETS_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause_toggle,
  input  logic       game_over,
  input  logic [3:0] level,
  input  logic       soft_drop,
  input  logic       grounded,
  input  logic       lock_reset,
  output logic       frame_tick,
  output logic       drop_tick,
  output logic       lock_tick,
  output logic       running,
  output logic       paused,
  output logic [5:0] frames_per_drop
);

  localparam int unsigned DIV   = CLK_HZ / FRAME_HZ;
  localparam logic [5:0]  SOFT6 = 6'(SOFT_DROP_FRAMES);
  localparam logic [6:0]  LOCK7 = 7'(LOCK_FRAMES);
  localparam logic [4:0]  MAXR5 = 5'(MAX_LOCK_RESETS);

  sched_state_t state, ret_state;
  logic [5:0]   drop_cnt, lock_cnt;
  logic [3:0]   reset_cnt;
  logic         tick;
  logic         run_state;
  logic         start_go;
  logic [5:0]   grav;
  logic [5:0]   fpd_next;

  assign run_state = (state == ST_RUN) || (state == ST_LOCK);
  // start is outranked by game_over except in IDLE/OVER, where game_over is ignored
  assign start_go  = start && ((state == ST_IDLE) || (state == ST_OVER) || !game_over);

  always_comb begin
    grav     = gravity_frames(level);
    fpd_next = grav;
    if (soft_drop && (grav > SOFT6)) fpd_next = SOFT6;
  end

  frame_prescaler #(.DIV(DIV)) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (run_state),
    .clear  (start_go),
    .tick   (tick)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state           <= ST_IDLE;
      ret_state       <= ST_RUN;
      drop_cnt        <= '0;
      lock_cnt        <= '0;
      reset_cnt       <= '0;
      frame_tick      <= 1'b0;
      drop_tick       <= 1'b0;
      lock_tick       <= 1'b0;
      running         <= 1'b0;
      paused          <= 1'b0;
      frames_per_drop <= 6'd48;
    end else begin
      frame_tick      <= tick && run_state && !start_go;
      drop_tick       <= 1'b0;
      lock_tick       <= 1'b0;
      running         <= run_state;
      paused          <= (state == ST_PAUSE);
      frames_per_drop <= fpd_next;

      if (start_go) begin
        state     <= ST_RUN;
        drop_cnt  <= '0;
        lock_cnt  <= '0;
        reset_cnt <= '0;
      end else begin
        case (state)
          ST_RUN: begin
            if (game_over) begin
              state <= ST_OVER;
            end else if (pause_toggle) begin
              state     <= ST_PAUSE;
              ret_state <= ST_RUN;
            end else if (grounded) begin
              state     <= ST_LOCK;
              lock_cnt  <= '0;
              reset_cnt <= '0;
            end else if (tick) begin
              // >= lets a freshly shortened period fire on the very next frame
              if (({1'b0, drop_cnt} + 7'd1) >= {1'b0, frames_per_drop}) begin
                drop_tick <= 1'b1;
                drop_cnt  <= '0;
              end else begin
                drop_cnt <= drop_cnt + 6'd1;
              end
            end
          end
          ST_LOCK: begin
            if (game_over) begin
              state <= ST_OVER;
            end else if (pause_toggle) begin
              state     <= ST_PAUSE;
              ret_state <= ST_LOCK;
            end else if (!grounded) begin
              state    <= ST_RUN;
              drop_cnt <= '0;
            end else if (lock_reset && ({1'b0, reset_cnt} < MAXR5)) begin
              lock_cnt  <= '0;
              reset_cnt <= reset_cnt + 4'd1;
            end else if (tick) begin
              if (({1'b0, lock_cnt} + 7'd1) == LOCK7) begin
                lock_tick <= 1'b1;
                state     <= ST_RUN;
                drop_cnt  <= '0;
              end else begin
                lock_cnt <= lock_cnt + 6'd1;
              end
            end
          end
          ST_PAUSE: begin
            if (game_over)         state <= ST_OVER;
            else if (pause_toggle) state <= ret_state;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_drop_scheduler.sv
// Directed testbench for drop_scheduler at 10 clocks per frame.
module tb_drop_scheduler;

  logic       clock = 1'b0;
  logic       reset, start, pause_toggle, game_over, soft_drop, grounded, lock_reset;
  logic [3:0] level;
  logic       frame_tick, drop_tick, lock_tick, running, paused;
  logic [5:0] frames_per_drop;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  drop_scheduler #(.CLK_HZ(600), .FRAME_HZ(60)) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .pause_toggle    (pause_toggle),
    .game_over       (game_over),
    .level           (level),
    .soft_drop       (soft_drop),
    .grounded        (grounded),
    .lock_reset      (lock_reset),
    .frame_tick      (frame_tick),
    .drop_tick       (drop_tick),
    .lock_tick       (lock_tick),
    .running         (running),
    .paused          (paused),
    .frames_per_drop (frames_per_drop)
  );

  // Advance to the next frame_tick (bounded). d/l are the drop/lock pulses on the
  // frame cycle; stray flags any drop/lock pulse on a non-frame cycle.
  task automatic next_frame(output bit seen, output bit d, output bit l, output bit stray);
    seen = 0; d = 0; l = 0; stray = 0;
    for (int i = 0; i < 15 && !seen; i++) begin
      @(negedge clock);
      if (frame_tick) begin
        seen = 1; d = drop_tick; l = lock_tick;
      end else if (drop_tick || lock_tick) begin
        stray = 1;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic test_reset();
    bit bad;
    reset = 1'b0; start = 0; pause_toggle = 0; game_over = 0;
    soft_drop = 0; grounded = 0; lock_reset = 0; level = 4'd0;
    repeat (3) @(negedge clock);
    vectors++;
    if ({frame_tick, drop_tick, lock_tick, running, paused} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 00000",
               {frame_tick, drop_tick, lock_tick, running, paused});
    end
    vectors++;
    if (frames_per_drop !== 6'd48) begin
      miscompares++;
      $display("FAIL reset_fpd: got %0d expected 48", frames_per_drop);
    end
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if ({frame_tick, drop_tick, lock_tick} !== 3'b000) begin
      miscompares++;
      $display("FAIL post_reset_pulse: got %b expected 000", {frame_tick, drop_tick, lock_tick});
    end
    bad = 0;
    repeat (30) begin
      @(negedge clock);
      if (frame_tick || drop_tick || lock_tick || running) bad = 1;
    end
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_quiet: got activity=%b expected 0", bad);
    end
  endtask

  task automatic test_gravity_table();
    logic [3:0] lv [8] = '{4'd0, 4'd8, 4'd9, 4'd12, 4'd13, 4'd15, 4'd10, 4'd13};
    logic       sd [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [5:0] ex [8] = '{6'd48, 6'd8, 6'd6, 6'd5, 6'd4, 6'd4, 6'd2, 6'd2};
    for (int i = 0; i < 8; i++) begin
      level = lv[i]; soft_drop = sd[i];
      @(negedge clock);
      vectors++;
      if (frames_per_drop !== ex[i]) begin
        miscompares++;
        $display("FAIL fpd_table[%0d]: level=%0d soft=%b got %0d expected %0d",
                 i, lv[i], sd[i], frames_per_drop, ex[i]);
      end
    end
    level = 4'd0; soft_drop = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_gravity_l0();
    bit s, d, l, st;
    level = 4'd0;
    pulse_start();
    @(negedge clock);
    vectors++;
    if (running !== 1'b1) begin
      miscompares++;
      $display("FAIL start_running: got %b expected 1", running);
    end
    for (int f = 1; f <= 96; f++) begin
      next_frame(s, d, l, st);
      vectors++;
      if ({s, d, l, st} !== {1'b1, (f % 48 == 0), 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL l0_frame%0d: got seen/drop/lock/stray=%b%b%b%b expected 1%b00",
                 f, s, d, l, st, (f % 48 == 0));
      end
    end
  endtask

  task automatic test_level_change();
    bit s, d, l, st;
    level = 4'd0;
    pulse_start();
    for (int f = 1; f <= 20; f++) begin
      next_frame(s, d, l, st);
      vectors++;
      if ({s, d, l, st} !== 4'b1000) begin
        miscompares++;
        $display("FAIL lvl_pre%0d: got %b%b%b%b expected 1000", f, s, d, l, st);
      end
    end
    level = 4'd9;
    @(negedge clock);
    vectors++;
    if (frames_per_drop !== 6'd6) begin
      miscompares++;
      $display("FAIL lvl9_fpd: got %0d expected 6", frames_per_drop);
    end
    next_frame(s, d, l, st);
    vectors++;
    if ({s, d, l, st} !== 4'b1100) begin
      miscompares++;
      $display("FAIL lvl_short_fire: got %b%b%b%b expected 1100", s, d, l, st);
    end
    for (int f = 1; f <= 12; f++) begin
      next_frame(s, d, l, st);
      vectors++;
      if ({s, d, l, st} !== {1'b1, (f % 6 == 0), 2'b00}) begin
        miscompares++;
        $display("FAIL lvl9_frame%0d: got %b%b%b%b expected 1%b00", f, s, d, l, st, (f % 6 == 0));
      end
    end
    soft_drop = 1'b1;
    @(negedge clock);
    vectors++;
    if (frames_per_drop !== 6'd2) begin
      miscompares++;
      $display("FAIL soft_fpd: got %0d expected 2", frames_per_drop);
    end
    for (int f = 1; f <= 6; f++) begin
      next_frame(s, d, l, st);
      vectors++;
      if ({s, d, l, st} !== {1'b1, (f % 2 == 0), 2'b00}) begin
        miscompares++;
        $display("FAIL soft_frame%0d: got %b%b%b%b expected 1%b00", f, s, d, l, st, (f % 2 == 0));
      end
    end
    soft_drop = 1'b0; level = 4'd0;
  endtask

  task automatic test_lock();
    bit s, d, l, st;
    level = 4'd9;
    pulse_start();
    next_frame(s, d, l, st);
    grounded = 1'b1;
    for (int f = 1; f <= 30; f++) begin
      next_frame(s, d, l, st);
      vectors++;
      if ({s, d, l, st} !== {1'b1, 1'b0, (f == 30), 1'b0}) begin
        miscompares++;
        $display("FAIL lock_frame%0d: got %b%b%b%b expected 10%b0", f, s, d, l, st, (f == 30));
      end
    end
    grounded = 1'b0;
    @(negedge clock);
    vectors++;
    if (running !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_running: got %b expected 1", running);
    end
    for (int f = 1; f <= 6; f++) begin
      next_frame(s, d, l, st);
      vectors++;
      if ({s, d, l, st} !== {1'b1, (f == 6), 2'b00}) begin
        miscompares++;
        $display("FAIL post_lock_frame%0d: got %b%b%b%b expected 1%b00", f, s, d, l, st, (f == 6));
      end
    end
  endtask

  task automatic test_lock_resets();
    bit s, d, l, st;
    level = 4'd9;
    pulse_start();
    next_frame(s, d, l, st);
    grounded = 1'b1;
    for (int r = 1; r <= 16; r++) begin
      for (int f = 1; f <= 20; f++) begin
        next_frame(s, d, l, st);
        vectors++;
        if ({s, d, l, st} !== 4'b1000) begin
          miscompares++;
          $display("FAIL lreset%0d_frame%0d: got %b%b%b%b expected 1000", r, f, s, d, l, st);
        end
      end
      lock_reset = 1'b1;
      @(negedge clock);
      lock_reset = 1'b0;
    end
    for (int f = 1; f <= 10; f++) begin
      next_frame(s, d, l, st);
      vectors++;
      if ({s, d, l, st} !== {2'b10, (f == 10), 1'b0}) begin
        miscompares++;
        $display("FAIL lreset_tail%0d: got %b%b%b%b expected 10%b0", f, s, d, l, st, (f == 10));
      end
    end
    grounded = 1'b0;
  endtask

  task automatic test_pause();
    bit s, d, l, st, bad;
    level = 4'd9;
    pulse_start();
    next_frame(s, d, l, st);
    grounded = 1'b1;
    for (int f = 1; f <= 12; f++) next_frame(s, d, l, st);
    pause_toggle = 1'b1;
    @(negedge clock);
    pause_toggle = 1'b0;
    bad = 0;
    repeat (200) begin
      @(negedge clock);
      if (frame_tick || drop_tick || lock_tick) bad = 1;
    end
    vectors++;
    if ({bad, paused, running} !== 3'b010) begin
      miscompares++;
      $display("FAIL pause_hold: got activity/paused/running=%b%b%b expected 010", bad, paused, running);
    end
    pause_toggle = 1'b1;
    @(negedge clock);
    pause_toggle = 1'b0;
    for (int f = 1; f <= 18; f++) begin
      next_frame(s, d, l, st);
      vectors++;
      if ({s, d, l, st} !== {2'b10, (f == 18), 1'b0}) begin
        miscompares++;
        $display("FAIL resume_frame%0d: got %b%b%b%b expected 10%b0", f, s, d, l, st, (f == 18));
      end
    end
    grounded = 1'b0;
    vectors++;
    if (paused !== 1'b0) begin
      miscompares++;
      $display("FAIL resume_paused: got %b expected 0", paused);
    end
  endtask

  task automatic test_over();
    bit s, d, l, st, bad;
    level = 4'd9;
    pulse_start();
    for (int f = 1; f <= 3; f++) next_frame(s, d, l, st);
    game_over = 1'b1; pause_toggle = 1'b1;
    @(negedge clock);
    game_over = 1'b0; pause_toggle = 1'b0;
    @(negedge clock);
    vectors++;
    if ({paused, running} !== 2'b00) begin
      miscompares++;
      $display("FAIL over_flags: got paused/running=%b%b expected 00", paused, running);
    end
    bad = 0;
    repeat (30) begin
      @(negedge clock);
      if (frame_tick || drop_tick || lock_tick || paused || running) bad = 1;
    end
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL over_quiet: got activity=%b expected 0", bad);
    end
    pulse_start();
    @(negedge clock);
    vectors++;
    if ({paused, running} !== 2'b01) begin
      miscompares++;
      $display("FAIL restart_flags: got paused/running=%b%b expected 01", paused, running);
    end
    for (int f = 1; f <= 6; f++) begin
      next_frame(s, d, l, st);
      vectors++;
      if ({s, d, l, st} !== {1'b1, (f == 6), 2'b00}) begin
        miscompares++;
        $display("FAIL restart_frame%0d: got %b%b%b%b expected 1%b00", f, s, d, l, st, (f == 6));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit s, d, l, st, bad;
    level = 4'd9; soft_drop = 1'b1;
    pulse_start();
    for (int f = 1; f <= 3; f++) next_frame(s, d, l, st);
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if ({frame_tick, drop_tick, lock_tick, running, paused, frames_per_drop} !== {5'b00000, 6'd48}) begin
      miscompares++;
      $display("FAIL mid_reset: got flags=%b fpd=%0d expected 00000 fpd=48",
               {frame_tick, drop_tick, lock_tick, running, paused}, frames_per_drop);
    end
    level = 4'd0; soft_drop = 1'b0;
    reset = 1'b1;
    bad = 0;
    repeat (25) begin
      @(negedge clock);
      if (frame_tick || drop_tick || lock_tick || running) bad = 1;
    end
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_idle: got activity=%b expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_gravity_table();
    test_gravity_l0();
    test_level_change();
    test_lock();
    test_lock_resets();
    test_pause();
    test_over();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/drop_scheduler.md
# drop_scheduler

Gravity and lock-delay scheduler for the Tetris core. It derives a 60 Hz frame tick from the system clock. From that tick it issues single-cycle `drop_tick` (move the piece down one row) and `lock_tick` (commit the piece to the stack) pulses at a rate set by the current level and soft-drop input. The piece/board logic consumes these pulses, and the top-level game FSM drives the start/pause/over control inputs.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `FRAME_HZ`, 60, frame tick rate; `CLK_HZ/FRAME_HZ` must be ≥ 2.
- `LOCK_FRAMES`, 30, frames a grounded piece waits before locking.
- `SOFT_DROP_FRAMES`, 2, frames per drop while soft drop is held.
- `MAX_LOCK_RESETS`, 15, lock-timer resets allowed per grounding.
- `clock  in  1  system clock, all logic on rising edge.`
- `reset  in  1  synchronous, active-low reset.`
- `start  in  1  pulse; begin or restart a game.`
- `pause_toggle  in  1  pulse; enter or leave pause.`
- `game_over  in  1  pulse; end the game.`
- `level  in  4  current level, 0..15.`
- `soft_drop  in  1  level; soft drop held.`
- `grounded  in  1  level; the piece cannot move down.`
- `lock_reset  in  1  pulse; the player moved or rotated a grounded piece.`
- `frame_tick  out  1  one-cycle pulse per frame while running.`
- `drop_tick  out  1  one-cycle gravity pulse.`
- `lock_tick  out  1  one-cycle lock pulse.`
- `running  out  1  high in RUN or LOCK.`
- `paused  out  1  high in PAUSE.`
- `frames_per_drop  out  6  effective gravity period, registered.`

## Operation
- The FSM has five states: IDLE, RUN, LOCK, PAUSE, OVER. Reset puts it in IDLE.
- Event priority each cycle is `game_over` > `start` > `pause_toggle` > `grounded`/`lock_reset`.
- IDLE / OVER: `start` → RUN, clearing the prescaler, `drop_cnt`, `lock_cnt` and `reset_cnt`. All other inputs are ignored.
- RUN:
  - `game_over` → OVER.
  - `start` restarts the game: it stays in RUN and clears all counters.
  - `pause_toggle` → PAUSE, with return state RUN.
  - `grounded` → LOCK, clearing `lock_cnt` and `reset_cnt`.
  - On each frame tick: if `drop_cnt+1 ≥ frames_per_drop`, it fires `drop_tick` and clears `drop_cnt`; otherwise it increments `drop_cnt`.
- LOCK:
  - No drop ticks are issued.
  - `!grounded` → RUN, clearing `drop_cnt`.
  - `lock_reset` with `reset_cnt < MAX_LOCK_RESETS` clears `lock_cnt` and increments `reset_cnt`. Once the limit is reached, `lock_reset` is ignored.
  - On each frame tick: if `lock_cnt+1 == LOCK_FRAMES`, it fires `lock_tick` and goes → RUN, clearing `drop_cnt`. Otherwise it increments `lock_cnt`.
- PAUSE:
  - The prescaler and all counters hold their values.
  - `pause_toggle` returns to the saved state, RUN or LOCK.
  - `game_over` → OVER; `start` → RUN, with all counters cleared.
- Gravity table for levels 0..15: 48, 43, 38, 33, 28, 23, 18, 13, 8, 6, 5, 5, 5, 4, 4, 4.
  - `frames_per_drop` is the table value, or `min(table, SOFT_DROP_FRAMES)` while `soft_drop` is held.
- A level or soft-drop change takes effect without waiting for the current period to finish. The `≥` compare guarantees that a shortened period fires on the next frame tick.

## Timing
- Reset values:
  - all pulse outputs 0;
  - `running`=0, `paused`=0;
  - `frames_per_drop`=48;
  - all counters 0; state IDLE.
- The prescaler counts 0..`CLK_HZ/FRAME_HZ-1`, but only in RUN and LOCK. `frame_tick` is registered and asserts for exactly one cycle in the cycle after the prescaler wraps.
- `drop_tick` and `lock_tick` are registered and assert in the same cycle as the `frame_tick` that completes their period. They are never both high in one cycle.
- State transitions take effect on the edge after the input is sampled. `running` and `paused` follow the state with one cycle of latency.
- `frames_per_drop` updates one cycle after a `level` or `soft_drop` change.
- Counter widths:
  - prescaler: `$clog2(CLK_HZ/FRAME_HZ)`;
  - `drop_cnt` and `lock_cnt`: 6 bits;
  - `reset_cnt`: 4 bits, saturating.
- Reset mid-operation aborts immediately and gives exactly the reset values above. No pulse is emitted in the cycle following reset deassertion.

## Structure
- Package `tetris_timing_pkg` holds:
  - the state enum;
  - the gravity-table function `gravity_frames(level)`;
  - the default `LOCK_FRAMES`, `SOFT_DROP_FRAMES` and `MAX_LOCK_RESETS` constants.
- Sub-module `frame_prescaler` is parameterised by `DIV`, with inputs `clock`, `reset`, `enable` and `clear` and a registered `tick` output. The FSM and counters stay in `drop_scheduler`.

## Test plan
All scenarios use `CLK_HZ=600`, `FRAME_HZ=60`, giving 10 clocks per frame.
- Reset, then `start` at level 0 → first `drop_tick` on the 48th `frame_tick` (≈480 clocks), then every 48 frames; `running`=1.
- Level 0 with `drop_cnt`=20, then `level`←9 → `drop_tick` on the next `frame_tick`, then every 6 frames; `soft_drop` held → every 2 frames.
- `grounded`=1 → no `drop_tick`; `lock_tick` after 30 frames, on a cycle with `frame_tick` high; state returns to RUN.
- In LOCK, `lock_reset` every 20 frames → the first 15 restart the timer; after the 16th is ignored, `lock_tick` fires 10 frames later.
- `pause_toggle` mid-LOCK at `lock_cnt`=12, hold for 200 clocks, then toggle again → no ticks while paused; `lock_tick` 18 frames after resuming.
- `game_over` and `pause_toggle` in the same cycle → OVER with `paused`=0; then `start` → RUN with counters cleared.
